// File: rtl/rll_key_loader.sv
// Serial key-load controller: shifts in a KEY_W-bit key plus an even-parity bit and commits it
// atomically to key_o. Optional lockout after repeated parity failures: define RLL_KEY_LOCKOUT_EN.
module rll_key_loader #(
    parameter int                 KEY_W       = 16,
    parameter logic [KEY_W-1:0]   KEY_DEFAULT = '0,
    parameter int                 MAX_FAIL    = 3,
    parameter int                 LOCK_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start_i,
    input  logic             bit_i,
    input  logic             bit_valid_i,
    output logic             bit_ready_o,
    output logic [KEY_W-1:0] key_o,
    output logic             key_valid_o,
    output logic             busy_o,
    output logic             err_o,
    output logic             locked_o
);

    localparam int CW = $clog2(KEY_W);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [KEY_W-1:0]  shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              key_valid_q, key_valid_d;
    logic              err_q, err_d;

`ifdef RLL_KEY_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCK_CYCLES);
    logic [FW-1:0]     fail_q, fail_d;
    logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            key_q       <= KEY_DEFAULT;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef RLL_KEY_LOCKOUT_EN
            fail_q      <= '0;
            lock_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
`ifdef RLL_KEY_LOCKOUT_EN
            fail_q      <= fail_d;
            lock_cnt_q  <= lock_cnt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        err_d       = 1'b0;
`ifdef RLL_KEY_LOCKOUT_EN
        fail_d      = fail_q;
        lock_cnt_d  = lock_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_start_i) begin
                    state_d = ST_SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                // A restart always beats a bit arriving on the same edge.
                if (load_start_i) begin
                    shift_d = '0;
                    cnt_d   = '0;
                end else if (bit_valid_i) begin
                    shift_d[cnt_q] = bit_i;
                    if (cnt_q == CW'(KEY_W - 1)) begin
                        state_d = ST_PARITY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (load_start_i) begin
                    state_d = ST_SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end else if (bit_valid_i) begin
                    state_d = ST_IDLE;
                    if (bit_i == ^shift_q) begin
                        key_d       = shift_q;
                        key_valid_d = 1'b1;
`ifdef RLL_KEY_LOCKOUT_EN
                        fail_d      = '0;
`endif
                    end else begin
                        err_d = 1'b1;
`ifdef RLL_KEY_LOCKOUT_EN
                        if (int'(fail_q) < MAX_FAIL) begin
                            fail_d = fail_q + 1'b1;
                        end
                        if (int'(fail_q) >= MAX_FAIL - 1) begin
                            state_d    = ST_LOCK;
                            lock_cnt_d = '0;
                        end
`endif
                    end
                end
            end
            ST_LOCK: begin
`ifdef RLL_KEY_LOCKOUT_EN
                if (lock_cnt_q == LW'(LOCK_CYCLES - 1)) begin
                    state_d    = ST_IDLE;
                    fail_d     = '0;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        bit_ready_o = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
        busy_o      = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
        key_o       = key_q;
        key_valid_o = key_valid_q;
        err_o       = err_q;
`ifdef RLL_KEY_LOCKOUT_EN
        locked_o    = (state_q == ST_LOCK);
`else
        locked_o    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed self-checking bench for rll_key_loader: a vector table of full loads plus
// hand-written sequences for restart, reset, idle-bit and lockout corner cases.
module tb_rll_key_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start_i;
    logic        bit_i;
    logic        bit_valid_i;
    logic        bit_ready_o;
    logic [15:0] key_o;
    logic        key_valid_o;
    logic        busy_o;
    logic        err_o;
    logic        locked_o;

    int n_cmp = 0;
    int n_bad = 0;

    rll_key_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start_i(load_start_i),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid_i),
        .bit_ready_o (bit_ready_o),
        .key_o       (key_o),
        .key_valid_o (key_valid_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .locked_o    (locked_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] key;
        logic        par;
        logic [15:0] exp_key;
        logic        exp_valid;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic start_load();
        load_start_i = 1'b1;
        @(negedge clk);
        load_start_i = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid_i = 1'b1;
            bit_i       = k[i];
            @(negedge clk);
        end
        bit_valid_i = 1'b0;
    endtask

    task automatic send_par(input logic p);
        bit_valid_i = 1'b1;
        bit_i       = p;
        @(negedge clk);
        bit_valid_i = 1'b0;
    endtask

    task automatic full_load(input logic [15:0] k, input logic p);
        start_load();
        send_bits(k, 16);
        send_par(p);
    endtask

    vec_t vecs[6];
    int   lock_len;

    initial begin
        vecs[0] = '{16'hA5C3, 1'b0, 16'hA5C3, 1'b1, 1'b0};
        vecs[1] = '{16'h0001, 1'b0, 16'hA5C3, 1'b1, 1'b1};
        vecs[2] = '{16'h1234, 1'b1, 16'h1234, 1'b1, 1'b0};
        vecs[3] = '{16'h00FF, 1'b0, 16'h00FF, 1'b1, 1'b0};
        vecs[4] = '{16'hFFFF, 1'b1, 16'h00FF, 1'b1, 1'b1};
        vecs[5] = '{16'h8000, 1'b1, 16'h8000, 1'b1, 1'b0};

        rst_n = 1'b0; load_start_i = 1'b0; bit_i = 1'b0; bit_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset key_o", key_o, 16'h0000);
        chk("reset key_valid", key_valid_o, 1'b0);
        chk("reset busy/ready/err/locked", {busy_o, bit_ready_o, err_o, locked_o}, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table: each entry is a complete load followed by commit/err checks
        for (int v = 0; v < 6; v++) begin
            start_load();
            chk("ready in SHIFT", bit_ready_o, 1'b1);
            send_bits(vecs[v].key, 16);
            send_par(vecs[v].par);
            chk("vec key_o", key_o, vecs[v].exp_key);
            chk("vec key_valid", key_valid_o, vecs[v].exp_valid);
            chk("vec err_o", err_o, vecs[v].exp_err);
            chk("vec busy after parity", busy_o, 1'b0);
            @(negedge clk);
            chk("vec err_o one-cycle", err_o, 1'b0);
            $display("vec %0d: key=%h par=%0d -> key_o=%h valid=%0d", v, vecs[v].key, vecs[v].par,
                     key_o, key_valid_o);
        end

        // Abort after 7 bits, then a clean 00FF load
        start_load();
        send_bits(16'h5555, 7);
        start_load();
        chk("restart busy", busy_o, 1'b1);
        chk("restart no err", err_o, 1'b0);
        chk("restart key held", key_o, 16'h8000);
        send_bits(16'h00FF, 16);
        send_par(1'b0);
        chk("restart commit key", key_o, 16'h00FF);
        $display("restart: key_o=%h", key_o);

        // load_start_i on the parity edge wins; bit is discarded
        start_load();
        send_bits(16'h0F0F, 16);
        load_start_i = 1'b1; bit_valid_i = 1'b1; bit_i = 1'b0;
        @(negedge clk);
        load_start_i = 1'b0; bit_valid_i = 1'b0;
        chk("restart-wins key held", key_o, 16'h00FF);
        chk("restart-wins back in SHIFT", busy_o, 1'b1);
        chk("restart-wins no err", err_o, 1'b0);
        send_bits(16'h0F0F, 16);
        send_par(1'b0);
        chk("restart-wins then commit", key_o, 16'h0F0F);
        $display("restart-on-parity: key_o=%h", key_o);

        // bit_valid_i in IDLE is ignored; next load still needs 17 bits
        bit_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bit_i = i[0];
            @(negedge clk);
        end
        bit_valid_i = 1'b0;
        chk("idle bits busy/ready", {busy_o, bit_ready_o}, 2'b00);
        chk("idle bits key held", key_o, 16'h0F0F);
        start_load();
        send_bits(16'h5A5A, 16);
        chk("16 bits not committed", key_o, 16'h0F0F);
        chk("16 bits still busy", busy_o, 1'b1);
        send_par(1'b0);
        chk("17th bit commits", key_o, 16'h5A5A);
        $display("idle-bits: key_o=%h", key_o);

        // Commit 1234 then async reset during a reload
        full_load(16'h1234, 1'b1);
        start_load();
        send_bits(16'hFFFF, 8);
        chk("reload holds old key", key_o, 16'h1234);
        chk("reload holds valid", key_valid_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst key_o", key_o, 16'h0000);
        chk("async rst valid/busy", {key_valid_o, busy_o}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("async reset: key_o=%h valid=%0d", key_o, key_valid_o);

        // Three bad loads
        for (int i = 0; i < 3; i++) begin
            full_load(16'h0001, 1'b0);
            chk("bad load err", err_o, 1'b1);
        end
`ifdef RLL_KEY_LOCKOUT_EN
        chk("locked after 3 bad", locked_o, 1'b1);
        chk("ready low in LOCK", bit_ready_o, 1'b0);
        lock_len = 0;
        load_start_i = 1'b1;
        while (locked_o && lock_len < 1000) begin
            lock_len++;
            @(negedge clk);
        end
        load_start_i = 1'b0;
        chk("lock duration", lock_len, 256);
        chk("start ignored in LOCK", busy_o, 1'b0);
        $display("lockout: %0d cycles", lock_len);
`else
        chk("no lockout in default build", locked_o, 1'b0);
        @(negedge clk);
`endif
        full_load(16'hA5C3, 1'b0);
        chk("post-fail commit", key_o, 16'hA5C3);
        chk("post-fail valid", key_valid_o, 1'b1);
        $display("post-fail load: key_o=%h", key_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
